// File: rtl/mem_arbiter.sv
// Two-master (instruction/data) to one-slave memory arbiter; optional MEM_ARBITER_RR_EN selects round-robin, else data priority with starvation guard.
// Latency: request on the bus one cycle after grant, response ready passed through combinationally, one idle cycle between transactions.
// Backpressure: the bus request is held frozen until memory_ready; the non-granted master simply waits with valid high.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nxt;
    logic   grant, grant_nxt;
    logic   load;
    logic   sel_d;

`ifdef MEM_ARBITER_RR_EN
    logic rr_ptr, rr_ptr_nxt;
`else
    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];
    logic [3:0] starve_cnt, starve_cnt_nxt;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        load      = 1'b0;
        sel_d     = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        rr_ptr_nxt = rr_ptr;
`else
        starve_cnt_nxt = starve_cnt;
`endif
        case (state)
            IDLE: begin
                if (imem_valid || dmem_valid) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
`ifdef MEM_ARBITER_RR_EN
                    if (imem_valid && dmem_valid)
                        sel_d = rr_ptr;
                    else
                        sel_d = dmem_valid;
                    // Prefer whoever did not win this grant next time.
                    rr_ptr_nxt = ~sel_d;
`else
                    sel_d = dmem_valid && !(imem_valid && (starve_cnt == LIMIT));
                    if (!sel_d)
                        starve_cnt_nxt = 4'd0;
                    else if (imem_valid)
                        starve_cnt_nxt = starve_cnt + 4'd1;
`endif
                    grant_nxt = sel_d;
                end
            end
            BUSY: begin
                if (memory_ready)
                    state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            rr_ptr <= 1'b0;
`else
            starve_cnt <= 4'd0;
`endif
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
`ifdef MEM_ARBITER_RR_EN
            rr_ptr <= rr_ptr_nxt;
`else
            starve_cnt <= starve_cnt_nxt;
`endif
        end
    end

    // Bus registers load only on a grant and stay frozen while BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memory_valid <= 1'b0;
            memory_instr <= 1'b0;
            memory_addr  <= 32'd0;
            memory_wdata <= 32'd0;
            memory_wstrb <= 4'd0;
        end else if (load) begin
            memory_valid <= 1'b1;
            memory_instr <= sel_d ? dmem_instr : imem_instr;
            memory_addr  <= sel_d ? dmem_addr  : imem_addr;
            memory_wdata <= sel_d ? dmem_wdata : imem_wdata;
            memory_wstrb <= sel_d ? dmem_wstrb : imem_wstrb;
        end else if (state == BUSY && memory_ready) begin
            memory_valid <= 1'b0;
        end
    end

    assign imem_ready = (state == BUSY) && !grant && memory_ready;
    assign dmem_ready = (state == BUSY) &&  grant && memory_ready;
    assign imem_rdata = memory_rdata;
    assign dmem_rdata = memory_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch/write, idle ready, frozen request, mid-busy reset, arbitration order.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_valid, imem_instr;
    logic [31:0] imem_addr, imem_wdata, imem_rdata;
    logic [3:0]  imem_wstrb;
    logic        imem_ready;
    logic        dmem_valid, dmem_instr;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic        memory_valid, memory_instr;
    logic [31:0] memory_addr, memory_wdata, memory_rdata;
    logic [3:0]  memory_wstrb;
    logic        memory_ready;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
        .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
        .memory_ready(memory_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic exp_d [10];

    initial begin
`ifdef MEM_ARBITER_RR_EN
        exp_d = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        rst = 1'b0;
        imem_valid = 0; imem_instr = 0; imem_addr = 0; imem_wdata = 0; imem_wstrb = 0;
        dmem_valid = 0; dmem_instr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
        memory_rdata = 32'h0; memory_ready = 1'b0;
        tick(); tick();

        chk("rst_valid", {31'd0, memory_valid}, 32'd0);
        chk("rst_instr", {31'd0, memory_instr}, 32'd0);
        chk("rst_addr",  memory_addr, 32'd0);
        chk("rst_wdata", memory_wdata, 32'd0);
        chk("rst_wstrb", {28'd0, memory_wstrb}, 32'd0);
        chk("rst_ready", {30'd0, imem_ready, dmem_ready}, 32'd0);
        rst = 1'b1;
        tick();

        // Single fetch
        imem_valid = 1; imem_instr = 1; imem_addr = 32'h0000_0100; imem_wstrb = 4'h0;
        tick();
        chk("fetch_valid", {31'd0, memory_valid}, 32'd1);
        chk("fetch_addr",  memory_addr, 32'h100);
        chk("fetch_instr", {31'd0, memory_instr}, 32'd1);
        memory_ready = 1; memory_rdata = 32'hCAFE_F00D;
        #1;
        chk("fetch_iready", {31'd0, imem_ready}, 32'd1);
        chk("fetch_dready", {31'd0, dmem_ready}, 32'd0);
        chk("fetch_rdata",  imem_rdata, 32'hCAFE_F00D);
        tick();
        memory_ready = 0; imem_valid = 0;
        #1;
        chk("fetch_done_valid", {31'd0, memory_valid}, 32'd0);
        chk("fetch_done_iready", {31'd0, imem_ready}, 32'd0);

        // Data write with one wait cycle from the slave
        dmem_valid = 1; dmem_instr = 0; dmem_addr = 32'h2000_0004;
        dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
        tick();
        chk("wr_valid", {31'd0, memory_valid}, 32'd1);
        chk("wr_addr",  memory_addr, 32'h2000_0004);
        chk("wr_wdata", memory_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", {28'd0, memory_wstrb}, 32'hF);
        chk("wr_instr", {31'd0, memory_instr}, 32'd0);
        tick();
        chk("wr_wait_valid",  {31'd0, memory_valid}, 32'd1);
        chk("wr_wait_dready", {31'd0, dmem_ready}, 32'd0);
        memory_ready = 1; memory_rdata = 32'h1234_5678;
        #1;
        chk("wr_dready", {31'd0, dmem_ready}, 32'd1);
        chk("wr_iready", {31'd0, imem_ready}, 32'd0);
        chk("wr_drdata", dmem_rdata, 32'h1234_5678);
        tick();
        memory_ready = 0; dmem_valid = 0;
        #1;
        chk("wr_done_valid", {31'd0, memory_valid}, 32'd0);
        chk("wr_done_dready", {31'd0, dmem_ready}, 32'd0);

        // Slave ready while idle
        memory_ready = 1;
        #1;
        chk("idle_ready", {30'd0, imem_ready, dmem_ready}, 32'd0);
        tick();
        chk("idle_valid", {31'd0, memory_valid}, 32'd0);
        memory_ready = 0;
        tick();
        chk("idle_valid2", {31'd0, memory_valid}, 32'd0);

        // Address change while busy is ignored
        imem_valid = 1; imem_instr = 1; imem_addr = 32'h0000_0400;
        tick();
        chk("hold_addr0", memory_addr, 32'h400);
        imem_addr = 32'h0000_0800;
        tick();
        chk("hold_addr1", memory_addr, 32'h400);
        memory_ready = 1;
        #1;
        chk("hold_iready", {31'd0, imem_ready}, 32'd1);
        tick();
        memory_ready = 0; imem_valid = 0;
        tick();

        // Reset while busy
        imem_valid = 1; imem_instr = 1; imem_addr = 32'h0000_0500;
        tick();
        chk("rb_valid", {31'd0, memory_valid}, 32'd1);
        rst = 0;
        #1;
        chk("rb_rst_valid", {31'd0, memory_valid}, 32'd0);
        chk("rb_rst_addr",  memory_addr, 32'd0);
        chk("rb_rst_instr", {31'd0, memory_instr}, 32'd0);
        tick();
        rst = 1;
        tick();
        chk("rb_regrant_valid", {31'd0, memory_valid}, 32'd1);
        chk("rb_regrant_addr",  memory_addr, 32'h500);
        memory_ready = 1;
        #1;
        chk("rb_iready", {31'd0, imem_ready}, 32'd1);
        tick();
        memory_ready = 0; imem_valid = 0;
        tick();

        // Fresh reset, then both masters request continuously
        rst = 0;
        tick();
        rst = 1;
        imem_valid = 1; imem_instr = 1; imem_addr = 32'h0000_1000; imem_wstrb = 4'h0;
        dmem_valid = 1; dmem_instr = 0; dmem_addr = 32'h0000_2000; dmem_wstrb = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("arb_addr%0d", i), memory_addr, exp_d[i] ? 32'h2000 : 32'h1000);
            memory_ready = 1;
            #1;
            chk($sformatf("arb_ready%0d", i), {30'd0, imem_ready, dmem_ready},
                exp_d[i] ? 32'd1 : 32'd2);
            tick();
            memory_ready = 0;
        end
        imem_valid = 0; dmem_valid = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
